// File: rtl/dqn_fixed_pkg.sv
// dqn_fixed_pkg: Q6.10 constants, opcodes and data type shared by the activation units
package dqn_fixed_pkg;
  localparam int W = 16;
  localparam int FRAC = 10;
  localparam int Q_ONE = 1 << FRAC;
  localparam logic [3:0] OP_SIGMOID = 4'b0011;
  localparam logic [3:0] OP_RELU = 4'b0010;
  typedef logic signed [W-1:0] q_t;
endpackage

// File: rtl/activation_backward_if.sv
// activation_backward_if: valid/ready beat stream into and out of the backward activation unit
interface activation_backward_if #(parameter int W = dqn_fixed_pkg::W);
  logic in_valid;
  logic in_ready;
  logic [3:0] ctrl;
  logic signed [W-1:0] act;
  logic signed [W-1:0] grad;
  logic out_valid;
  logic out_ready;
  logic signed [W-1:0] dout;
  logic [7:0] clamp_cnt;
  modport master(output in_valid, ctrl, act, grad, out_ready, input in_ready, out_valid, dout, clamp_cnt);
  modport slave(input in_valid, ctrl, act, grad, out_ready, output in_ready, out_valid, dout, clamp_cnt);
endinterface

// File: rtl/q_mul.sv
// q_mul: signed fixed-point multiply, full-width product shifted right arithmetically by FRAC
module q_mul #(
  parameter int W = dqn_fixed_pkg::W,
  parameter int FRAC = dqn_fixed_pkg::FRAC
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  logic signed [2*W-1:0] m;
  always_comb begin
    m = (2*W)'(a) * (2*W)'(b);
    y = W'(m >>> FRAC);
  end
endmodule

// File: rtl/activation_backward.sv
// activation_backward: 3-stage sigmoid'/ReLU'/identity local gradient with valid/ready on both sides
module activation_backward #(
  parameter int W = dqn_fixed_pkg::W,
  parameter int FRAC = dqn_fixed_pkg::FRAC
) (
  input logic clk,
  input logic rst_n,
  activation_backward_if.slave bus
);
  import dqn_fixed_pkg::*;
  localparam logic signed [W-1:0] ONE = W'(Q_ONE);
  logic en, oor, v1, v2, sg2, k2;
  logic [3:0] c1;
  logic signed [W-1:0] ac, a1, s1, g1, p2, g2, pm, dm;
  always_comb begin
    en = !bus.out_valid || bus.out_ready;
    bus.in_ready = en;
    oor = bus.act[W-1] || bus.act > ONE;
    ac = bus.act[W-1] ? '0 : bus.act > ONE ? ONE : bus.act;
  end
  q_mul #(.W(W), .FRAC(FRAC)) u_as (.a(a1), .b(s1), .y(pm));
  q_mul #(.W(W), .FRAC(FRAC)) u_gp (.a(g2), .b(p2), .y(dm));
  // ReLU reuses the clamped operand: clamp(z) != 0 exactly when z > 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      c1 <= '0;
      a1 <= '0;
      s1 <= '0;
      g1 <= '0;
      v2 <= 1'b0;
      sg2 <= 1'b0;
      k2 <= 1'b0;
      p2 <= '0;
      g2 <= '0;
      bus.out_valid <= 1'b0;
      bus.dout <= '0;
      bus.clamp_cnt <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      c1 <= bus.ctrl;
      a1 <= ac;
      s1 <= ONE - ac;
      g1 <= bus.grad;
      v2 <= v1;
      sg2 <= c1 == OP_SIGMOID;
      k2 <= c1 != OP_RELU || a1 != '0;
      p2 <= pm;
      g2 <= g1;
      bus.out_valid <= v2;
      if (v2) bus.dout <= sg2 ? dm : k2 ? g2 : '0;
      if (bus.in_valid && bus.ctrl == OP_SIGMOID && oor && bus.clamp_cnt != 8'hff)
        bus.clamp_cnt <= bus.clamp_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_activation_backward.sv
// tb_activation_backward: table-driven vectors plus backpressure, saturation and reset sequences
module tb_activation_backward;
  import dqn_fixed_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  activation_backward_if #(.W(W)) bus ();
  activation_backward #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [3:0] ctrl;
    q_t act;
    q_t grad;
    q_t exp;
  } vec_t;
  vec_t tv[14];
  q_t exp_q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", n, got, want);
    end
  endtask
  always @(negedge clk) begin
    q_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0d, want no beat", bus.dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout", bus.dout, e);
      end
    end
  end
  task automatic send(input logic [3:0] c, input q_t a, input q_t g, input q_t e);
    int t = 0;
    bus.in_valid = 1;
    bus.ctrl = c;
    bus.act = a;
    bus.grad = g;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 6) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    q_t held;
    bus.in_valid = 0;
    bus.ctrl = 0;
    bus.act = 0;
    bus.grad = 0;
    bus.out_ready = 1;
    tv[0]  = '{OP_SIGMOID, 16'sd512, 16'sd1024, 16'sd256};
    tv[1]  = '{OP_SIGMOID, 16'sd768, -16'sd2048, -16'sd384};
    tv[2]  = '{OP_SIGMOID, 16'sd256, 16'sd1000, 16'sd187};
    tv[3]  = '{OP_SIGMOID, 16'sd100, -16'sd3, -16'sd1};
    tv[4]  = '{OP_SIGMOID, 16'sd0, 16'sd1000, 16'sd0};
    tv[5]  = '{OP_SIGMOID, 16'sd1024, 16'sd1000, 16'sd0};
    tv[6]  = '{OP_RELU, -16'sd5120, 16'sd300, 16'sd0};
    tv[7]  = '{OP_RELU, 16'sd0, 16'sd300, 16'sd0};
    tv[8]  = '{OP_RELU, 16'sd1, 16'sd300, 16'sd300};
    tv[9]  = '{4'b0000, 16'sd7, -16'sd77, -16'sd77};
    tv[10] = '{OP_RELU, 16'sd2000, 16'sd7, 16'sd7};
    tv[11] = '{OP_RELU, -16'sd1, 16'sd5, 16'sd0};
    tv[12] = '{4'b1111, -16'sd100, 16'sd12345, 16'sd12345};
    tv[13] = '{4'b0001, 16'sd3000, -16'sd9, -16'sd9};
    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_clamp_cnt", int'(bus.clamp_cnt), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) send(tv[i].ctrl, tv[i].act, tv[i].grad, tv[i].exp);
    drain();
    chk("clamp_cnt_in_range", int'(bus.clamp_cnt), 0);
    send(OP_SIGMOID, -16'sd100, 16'sd1024, 16'sd0);
    send(OP_SIGMOID, 16'sd2000, 16'sd1024, 16'sd0);
    chk("clamp_cnt_two", int'(bus.clamp_cnt), 2);
    drain();
    bus.out_ready = 0;
    fork
      for (int i = 0; i < 6; i++) send(4'b0000, 16'sd0, q_t'(100 + i), q_t'(100 + i));
      begin
        repeat (3) @(negedge clk);
        @(negedge clk);
        held = bus.dout;
        chk("bp_full_in_ready", int'(bus.in_ready), 0);
        chk("bp_full_out_valid", int'(bus.out_valid), 1);
        chk("bp_first_dout", held, 100);
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready_low", int'(bus.in_ready), 0);
          chk("bp_dout_hold", bus.dout, held);
        end
        @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    chk("bp_all_out", exp_q.size(), 0);
    for (int i = 0; i < 300; i++) send(OP_SIGMOID, -16'sd1, 16'sd50, 16'sd0);
    drain();
    chk("clamp_cnt_sat", int'(bus.clamp_cnt), 255);
    send(OP_SIGMOID, 16'sd512, 16'sd1024, 16'sd256);
    send(OP_RELU, 16'sd5, 16'sd11, 16'sd11);
    send(4'b0000, 16'sd0, -16'sd22, -16'sd22);
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    rst_n = 0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_clamp_cnt", int'(bus.clamp_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(OP_SIGMOID, 16'sd768, -16'sd2048, -16'sd384);
    @(negedge clk);
    chk("lat_cycle1", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_cycle3", int'(bus.out_valid), 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
